// File: rtl/riu_pkg.sv
// riu_pkg: shared opcodes, CSR addresses, ALU and writeback-select encodings for the decode/execute stage
package riu_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] CSR_IO_IN  = 12'hF00;
    localparam logic [11:0] CSR_IO_OUT = 12'hF02;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_ADD   = 4'b0011,
        ALU_SUB   = 4'b0100,
        ALU_MUL   = 4'b0101,
        ALU_MULH  = 4'b0110,
        ALU_MULHU = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1100,
        ALU_SLTU  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_GPIO  = 2'b00,
        SEL_IMM20 = 2'b01,
        SEL_ALU   = 2'b10
    } regsel_e;

    function automatic logic is_shift(input alu_op_e op);
        return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    endfunction

endpackage

// File: rtl/riu_decode_exec_if.sv
// riu_decode_exec_if: instruction/register-file inputs and writeback outputs of the decode/execute stage
interface riu_decode_exec_if;
    logic [31:0] instruction;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        gpio_we;
    logic [31:0] r_wb;
    logic [4:0]  rd_wb;
    logic        regwrite_wb;
    logic [1:0]  regsel_wb;
    logic [31:0] imm20_wb;
    logic        zero;

    modport master (
        output instruction, readdata1, readdata2,
        input  rs1, rs2, gpio_we, r_wb, rd_wb, regwrite_wb, regsel_wb, imm20_wb, zero
    );

    modport slave (
        input  instruction, readdata1, readdata2,
        output rs1, rs2, gpio_we, r_wb, rd_wb, regwrite_wb, regsel_wb, imm20_wb, zero
    );
endinterface

// File: rtl/riu_alu.sv
// riu_alu: combinational RV32I(+M) ALU; multiplier present only when RIU_MUL_EN is defined
module riu_alu
    import riu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] r,
    output logic        zero
);

`ifdef RIU_MUL_EN
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};
`endif

    // select the result for the requested operation; unused codes give zero
    always_comb begin
        case (op)
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
`ifdef RIU_MUL_EN
            ALU_MUL:   r = prod_s[31:0];
            ALU_MULH:  r = prod_s[63:32];
            ALU_MULHU: r = 32'(prod_u >> 32);
`endif
            ALU_SLL:   r = a << b[4:0];
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {31'b0, a < b};
            default:   r = '0;
        endcase
    end

    assign zero = (r == '0);

endmodule

// File: rtl/riu_decode_exec.sv
// riu_decode_exec: decode, control, ALU and EX->WB register; RIU_MUL_EN enables MUL/MULH/MULHU
module riu_decode_exec
    import riu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    riu_decode_exec_if.slave         bus
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [31:0] imm20;
    logic [31:0] op_b;
    logic [31:0] alu_r;
    alu_op_e     aluop;
    regsel_e     regsel;
    logic        alusrc;
    logic        regwrite;
    logic        gpio_we;

    assign opcode  = bus.instruction[6:0];
    assign rd      = bus.instruction[11:7];
    assign funct3  = bus.instruction[14:12];
    assign funct7  = bus.instruction[31:25];
    assign imm12   = bus.instruction[31:20];
    assign imm20   = {bus.instruction[31:12], 12'b0};
    assign bus.rs1 = bus.instruction[19:15];
    assign bus.rs2 = bus.instruction[24:20];

    // control decode; anything unrecognised falls back to a NOP (ADD, no write)
    always_comb begin
        aluop    = ALU_ADD;
        alusrc   = 1'b0;
        regsel   = SEL_ALU;
        regwrite = 1'b0;
        gpio_we  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regwrite = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: aluop = ALU_ADD;
                    {7'b0000000, 3'b001}: aluop = ALU_SLL;
                    {7'b0000000, 3'b010}: aluop = ALU_SLT;
                    {7'b0000000, 3'b011}: aluop = ALU_SLTU;
                    {7'b0000000, 3'b100}: aluop = ALU_XOR;
                    {7'b0000000, 3'b101}: aluop = ALU_SRL;
                    {7'b0000000, 3'b110}: aluop = ALU_OR;
                    {7'b0000000, 3'b111}: aluop = ALU_AND;
                    {7'b0100000, 3'b000}: aluop = ALU_SUB;
                    {7'b0100000, 3'b101}: aluop = ALU_SRA;
`ifdef RIU_MUL_EN
                    {7'b0000001, 3'b000}: aluop = ALU_MUL;
                    {7'b0000001, 3'b001}: aluop = ALU_MULH;
                    {7'b0000001, 3'b011}: aluop = ALU_MULHU;
`endif
                    default:              regwrite = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
                case (funct3)
                    3'b000: aluop = ALU_ADD;
                    3'b001: aluop = ALU_SLL;
                    3'b010: aluop = ALU_SLT;
                    3'b011: aluop = ALU_SLTU;
                    3'b100: aluop = ALU_XOR;
                    3'b101: aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: aluop = ALU_OR;
                    default: aluop = ALU_AND;
                endcase
            end
            OP_LUI: begin
                regsel   = SEL_IMM20;
                regwrite = 1'b1;
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b001 && imm12 == CSR_IO_IN) begin
                    regsel   = SEL_GPIO;
                    regwrite = 1'b1;
                end else if (funct3 == 3'b001 && imm12 == CSR_IO_OUT) begin
                    gpio_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.gpio_we = gpio_we;

    // shift immediates use only the 5-bit shamt; other immediates are sign-extended
    assign op_b = !alusrc ? bus.readdata2 :
                  is_shift(aluop) ? {27'b0, imm12[4:0]} : {{20{imm12[11]}}, imm12};

    riu_alu u_alu (
        .a    (bus.readdata1),
        .b    (op_b),
        .op   (aluop),
        .r    (alu_r),
        .zero (bus.zero)
    );

    // EX->WB register; reset discards the in-flight writeback and writes to x0 are suppressed
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.r_wb        <= '0;
            bus.rd_wb       <= '0;
            bus.regwrite_wb <= 1'b0;
            bus.regsel_wb   <= '0;
            bus.imm20_wb    <= '0;
        end else begin
            bus.r_wb        <= alu_r;
            bus.rd_wb       <= rd;
            bus.regwrite_wb <= regwrite & (rd != 5'd0);
            bus.regsel_wb   <= regsel;
            bus.imm20_wb    <= imm20;
        end
    end

endmodule

// File: tb/tb_riu_decode_exec.sv
// tb_riu_decode_exec: table-driven directed checks of decode, ALU and EX->WB register
module tb_riu_decode_exec;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    riu_decode_exec_if bus ();

    riu_decode_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef RIU_MUL_EN
    localparam logic [31:0] MUL_R  = 32'd15;
    localparam logic        MUL_RW = 1'b1;
`else
    localparam logic [31:0] MUL_R  = 32'd8;
    localparam logic        MUL_RW = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  m;
        logic [31:0] r;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] imm;
        logic        gw;
        logic        z;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        v[0]  = '{1'b0, 32'h00500093, 32'h0, 32'h0, 3'b111, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
        v[1]  = '{1'b0, 32'h00500093, 32'h0, 32'h0, 3'b111, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0};
        v[2]  = '{1'b1, 32'h00500093, 32'h0, 32'h0, 3'b111, 32'h5, 5'd1, 1'b1, 2'd2, 32'h00500000, 1'b0, 1'b0};
        v[3]  = '{1'b1, 32'h12345137, 32'h0, 32'h0, 3'b010, 32'h0, 5'd2, 1'b1, 2'd1, 32'h12345000, 1'b0, 1'b0};
        v[4]  = '{1'b1, 32'h402081B3, 32'h3, 32'h5, 3'b111, 32'hFFFFFFFE, 5'd3, 1'b1, 2'd2, 32'h40208000, 1'b0, 1'b0};
        v[5]  = '{1'b1, 32'h4040D213, 32'h80000000, 32'h0, 3'b111, 32'hF8000000, 5'd4, 1'b1, 2'd2, 32'h4040D000, 1'b0, 1'b0};
        v[6]  = '{1'b1, 32'h0040D213, 32'h80000000, 32'h0, 3'b111, 32'h08000000, 5'd4, 1'b1, 2'd2, 32'h0040D000, 1'b0, 1'b0};
        v[7]  = '{1'b1, 32'hF00011F3, 32'h0, 32'h0, 3'b010, 32'h0, 5'd3, 1'b1, 2'd0, 32'hF0001000, 1'b0, 1'b0};
        v[8]  = '{1'b1, 32'hF0229073, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0, 2'd0, 32'hF0229000, 1'b1, 1'b0};
        v[9]  = '{1'b1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 3'b111, 32'h0, 5'd31, 1'b0, 2'd2, 32'hFFFFF000, 1'b0, 1'b1};
        v[10] = '{1'b1, 32'h00208033, 32'h7, 32'h9, 3'b111, 32'd16, 5'd0, 1'b0, 2'd2, 32'h00208000, 1'b0, 1'b0};
        v[11] = '{1'b1, 32'h0020A2B3, 32'hFFFFFFFF, 32'h1, 3'b111, 32'h1, 5'd5, 1'b1, 2'd2, 32'h0020A000, 1'b0, 1'b0};
        v[12] = '{1'b1, 32'h0020B2B3, 32'hFFFFFFFF, 32'h1, 3'b111, 32'h0, 5'd5, 1'b1, 2'd2, 32'h0020B000, 1'b0, 1'b1};
        v[13] = '{1'b1, 32'h02208333, 32'h3, 32'h5, 3'b111, MUL_R, 5'd6, MUL_RW, 2'd2, 32'h02208000, 1'b0, 1'b0};
        v[14] = '{1'b1, 32'hFFF0C393, 32'h0F0F0F0F, 32'h0, 3'b111, 32'hF0F0F0F0, 5'd7, 1'b1, 2'd2, 32'hFFF0C000, 1'b0, 1'b0};
        v[15] = '{1'b1, 32'h01F09413, 32'h3, 32'h0, 3'b111, 32'h80000000, 5'd8, 1'b1, 2'd2, 32'h01F09000, 1'b0, 1'b0};

        bus.instruction = '0;
        bus.readdata1   = '0;
        bus.readdata2   = '0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst             = v[i].rst;
            bus.instruction = v[i].ins;
            bus.readdata1   = v[i].d1;
            bus.readdata2   = v[i].d2;
            #2;
            chk($sformatf("v%0d gpio_we", i), 32'(bus.gpio_we), 32'(v[i].gw));
            if (v[i].m[2]) chk($sformatf("v%0d zero", i), 32'(bus.zero), 32'(v[i].z));
            @(posedge clk);
            #1;
            if (v[i].m[0]) chk($sformatf("v%0d r_wb", i), bus.r_wb, v[i].r);
            if (v[i].m[1]) chk($sformatf("v%0d regsel_wb", i), 32'(bus.regsel_wb), 32'(v[i].sel));
            chk($sformatf("v%0d rd_wb", i), 32'(bus.rd_wb), 32'(v[i].rd));
            chk($sformatf("v%0d regwrite_wb", i), 32'(bus.regwrite_wb), 32'(v[i].rw));
            chk($sformatf("v%0d imm20_wb", i), bus.imm20_wb, v[i].imm);
        end

        @(negedge clk);
        rst             = 1'b1;
        bus.instruction = 32'h00500093;
        bus.readdata1   = 32'd10;
        @(posedge clk);
        #1;
        chk("seq addi r_wb", bus.r_wb, 32'd15);
        chk("seq addi regwrite_wb", 32'(bus.regwrite_wb), 32'd1);
        @(negedge clk);
        rst             = 1'b0;
        bus.instruction = 32'hF0229073;
        #2;
        chk("seq reset gpio_we", 32'(bus.gpio_we), 32'd1);
        chk("seq reset rs1", 32'(bus.rs1), 32'd5);
        chk("seq reset rs2", 32'(bus.rs2), 32'd2);
        @(posedge clk);
        #1;
        chk("seq reset r_wb", bus.r_wb, 32'd0);
        chk("seq reset rd_wb", 32'(bus.rd_wb), 32'd0);
        chk("seq reset regwrite_wb", 32'(bus.regwrite_wb), 32'd0);
        chk("seq reset imm20_wb", bus.imm20_wb, 32'd0);
        @(negedge clk);
        rst             = 1'b1;
        bus.instruction = 32'h12345137;
        @(posedge clk);
        #1;
        chk("seq resume imm20_wb", bus.imm20_wb, 32'h12345000);
        chk("seq resume regsel_wb", 32'(bus.regsel_wb), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riu_decode_exec.md
Name: riu_decode_exec

Overview:
- Decode/execute stage of the single-issue RISC-V RV32I+M subset core (R-type, I-type ALU, LUI, CSRRW to I/O CSRs).
- Contains three parts: a field decoder, a control unit, and a combinational ALU with its operand-B mux.
- Also holds the EX→WB pipeline register.
- The register file, instruction memory, writeback mux and the gpio_out register live outside this block in the cpu top.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- instruction  in  32  current EX-stage instruction word
- readdata1  in  32  register file port 1 data (rs1)
- readdata2  in  32  register file port 2 data (rs2)
- rs1  out  5  register file read address 1, combinational = instruction[19:15]
- rs2  out  5  register file read address 2, combinational = instruction[24:20]
- gpio_we  out  1  combinational; top loads gpio_out with readdata1 when high
- r_wb  out  32  registered ALU result
- rd_wb  out  5  registered destination register
- regwrite_wb  out  1  registered write enable, forced 0 when rd_wb==0
- regsel_wb  out  2  registered writeback select: 00 gpio_in, 01 imm20, 10 ALU, 11 zero
- imm20_wb  out  32  registered {instruction[31:12],12'b0}
- zero  out  1  combinational, high when ALU result == 0

Behaviour:
- Decode field positions:
  - opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25]
  - imm12 = csr = [31:20]
  - imm20 = {[31:12],12'b0}
- ALU op encoding (4 bit):
  - 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB
  - 0101 MUL (low 32 bits), 0110 MULH (signed×signed, high 32), 0111 MULHU (unsigned, high 32)
  - 1000 SLL, 1001 SRL, 1010 SRA (shift amount = B[4:0])
  - 1100 SLT (signed, result 1/0), 1101 SLTU
  - all other codes: R = 0
  - All arithmetic wraps modulo 2^32.
- Operand A = readdata1.
- Operand B:
  - alusrc=0: readdata2.
  - alusrc=1 and op ∈ {SLL,SRL,SRA}: {27'b0, imm12[4:0]}.
  - alusrc=1, otherwise: sign-extended imm12.
- Control decode, all combinational:
  - Opcode 0110011 (R-type), alusrc 0, regsel 10, regwrite 1:
    - funct7 0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7 0100000: f3 000 SUB, f3 101 SRA.
    - funct7 0000001: f3 000 MUL, 001 MULH, 011 MULHU.
  - Opcode 0010011 (I-type), alusrc 1, regsel 10, regwrite 1:
    - f3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
    - f3 001 SLLI, f3 101 SRLI/SRAI, selected by funct7[5].
  - Opcode 0110111 LUI: regsel 01, regwrite 1.
  - Opcode 1110011 with f3 001 (CSRRW):
    - csr 0xF00: regsel 00, regwrite 1 (reads gpio_in into rd).
    - csr 0xF02: gpio_we 1, regwrite 0.
    - Other CSR addresses are illegal.
  - Any other combination is illegal and acts as a NOP: regwrite 0, gpio_we 0, aluop ADD, alusrc 0, regsel 10.
- Pipeline register, one-cycle latency:
  - On each posedge, r_wb, rd_wb, regwrite_wb, regsel_wb and imm20_wb capture the EX values.
  - regwrite_wb = regwrite & (rd != 0).
- Reset: when rst=0 at a posedge, all *_wb outputs clear to 0. The reset-state regsel is therefore 00 with regwrite 0, i.e. no write.
- Reset mid-stream: the in-flight instruction's writeback is discarded.
- The combinational outputs (rs1, rs2, gpio_we, zero) follow instruction regardless of reset.

Optional Feature:
- Macro: RIU_MUL_EN
- Defined: MUL, MULH and MULHU are decoded and computed.
- Undefined:
  - funct7 0000001 R-type is illegal (NOP).
  - ALU codes 0101–0111 return 0.
  - No multiplier is synthesized.

Decomposition:
- Package riu_pkg:
  - Opcode constants (OP_RTYPE, OP_ITYPE, OP_LUI, OP_SYSTEM).
  - ALU op enum (4-bit).
  - regsel enum (SEL_GPIO, SEL_IMM20, SEL_ALU).
  - CSR address constants CSR_IO_IN=0xF00, CSR_IO_OUT=0xF02.
- One natural sub-module: riu_alu (A, B, op → R, zero).
- Decoder and control are combinational logic inside the top.

Test Plan:
- Reset: rst=0 for 2 cycles with a legal instruction present → all *_wb = 0.
- ADDI: 0x00500093 (addi x1,x0,5), readdata1=0 → next cycle r_wb=5, rd_wb=1, regwrite_wb=1, regsel_wb=10.
- LUI: 0x12345137 (lui x2,0x12345) → imm20_wb=0x12345000, rd_wb=2, regsel_wb=01, regwrite_wb=1.
- SUB: 0x402081B3 (sub x3,x1,x2), readdata1=3, readdata2=5 → r_wb=0xFFFFFFFE, zero=0 during EX.
- SRAI: 0x4040D213 (srai x4,x1,4), readdata1=0x80000000 → r_wb=0xF8000000; same with SRLI 0x0040D213 → 0x08000000.
- CSRRW:
  - 0xF00011F3 → regsel_wb=00, rd_wb=3, regwrite_wb=1.
  - 0xF0229073 → gpio_we=1 combinational, regwrite_wb=0.
  - 0xFFFFFFFF (illegal) → gpio_we=0, regwrite_wb=0.
